fft_reorder_buffer: RTL and testbench

Parametrised ping-pong frame buffer for the FFT datapath: accepts N complex samples per frame in natural order and emits them in bit-reversed (or natural) order on a ready/valid stream. On the way out it widens each component from IN_W/2 to OUT_W/2 bits with a per-frame arithmetic left shift and saturation. It is the generalised replacement for the fixed 256-point bit-reversal-plus-widening glue, and adds full backpressure, double buffering, runtime reorder bypass and frame framing signals.

---
 rtl/fft_reorder_buffer.sv | 130 +++++++++++++
 tb/tb_fft_reorder_buffer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buffer.sv
// fft_reorder_buffer: ping-pong frame buffer with bit-reversal, per-frame widening shift and saturation
module fft_reorder_buffer #(
    parameter int N       = 256,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 36,
    parameter int SHIFT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reorder_en,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               out_sat,
    output logic               done
);
    localparam int LOG2N = $clog2(N);
    localparam int H = IN_W / 2;
    localparam int O = OUT_W / 2;
    localparam int E = (O > H + (1 << SHIFT_W) - 1) ? O : H + (1 << SHIFT_W) - 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = a[LOG2N-1-i];
    endfunction

    // returns {saturated, widened component}
    function automatic logic [O:0] widen(input logic [H-1:0] x, input logic [SHIFT_W-1:0] s);
        logic [E-1:0] v;
        logic         sat;
        v   = {{(E-H){x[H-1]}}, x} << s;
        sat = v[E-1:O-1] != {(E-O+1){v[O-1]}};
        return {sat, sat ? {v[E-1], {(O-1){~v[E-1]}}} : v[O-1:0]};
    endfunction

    logic [IN_W-1:0]    r_mem [2*N];
    bank_t              r_bst [2];
    bank_t              w_bst_nxt [2];
    logic               r_wsel, r_rsel, r_obank, r_ov, r_last, r_sat, r_done;
    logic [LOG2N-1:0]   r_wcnt, r_rcnt, w_waddr;
    logic [1:0]         r_rev;
    logic [SHIFT_W-1:0] r_shf [2];
    logic [SHIFT_W-1:0] r_oshf;
    logic [IN_W-1:0]    r_rd;
    logic               w_wr, w_rd, w_adv, w_xfer, w_rel;
    logic [O:0]         w_re, w_im;

    // handshakes, write address and widened output
    always_comb begin
        in_ready  = (r_bst[r_wsel] == EMPTY) || (r_bst[r_wsel] == FILLING);
        w_wr      = in_valid && in_ready;
        w_adv     = !r_ov || out_ready;
        w_rd      = w_adv && ((r_bst[r_rsel] == FULL) || (r_bst[r_rsel] == DRAINING));
        w_xfer    = r_ov && out_ready;
        w_rel     = w_xfer && r_last;
        w_waddr   = ((r_wcnt == '0) ? reorder_en : r_rev[r_wsel]) ? bitrev(r_wcnt) : r_wcnt;
        w_re      = widen(r_rd[IN_W-1:H], r_oshf);
        w_im      = widen(r_rd[H-1:0], r_oshf);
        out_data  = {w_re[O-1:0], w_im[O-1:0]};
        out_valid = r_ov;
        out_last  = r_ov && r_last;
        out_sat   = r_ov && (r_sat || w_re[O] || w_im[O]);
        done      = r_done;
    end

    // bank lifecycle: writer fills, reader claims on first issue, release on the last output transfer
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_bst_nxt[b] = r_bst[b];
            if (w_wr && r_wsel == 1'(b)) w_bst_nxt[b] = (r_wcnt == LAST) ? FULL : FILLING;
            if (w_rd && r_rsel == 1'(b)) w_bst_nxt[b] = DRAINING;
            if (w_rel && r_obank == 1'(b)) w_bst_nxt[b] = EMPTY;
        end
    end

    // sample storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[{r_wsel, w_waddr}] <= in_data;
    end

    // counters, bank toggles, side-band and the registered read stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_bst[b] <= EMPTY;
                r_shf[b] <= '0;
            end
            r_rev   <= '0;
            r_wsel  <= 1'b0;
            r_rsel  <= 1'b0;
            r_obank <= 1'b0;
            r_wcnt  <= '0;
            r_rcnt  <= '0;
            r_ov    <= 1'b0;
            r_last  <= 1'b0;
            r_sat   <= 1'b0;
            r_done  <= 1'b0;
            r_rd    <= '0;
            r_oshf  <= '0;
        end else begin
            r_bst <= w_bst_nxt;
            if (w_wr) begin
                r_wcnt <= r_wcnt + 1'b1;
                if (r_wcnt == LAST) r_wsel <= ~r_wsel;
                if (r_wcnt == '0) begin
                    r_rev[r_wsel] <= reorder_en;
                    r_shf[r_wsel] <= shift;
                end
            end
            if (w_rd) begin
                r_rcnt <= r_rcnt + 1'b1;
                if (r_rcnt == LAST) r_rsel <= ~r_rsel;
                r_rd    <= r_mem[{r_rsel, r_rcnt}];
                r_last  <= r_rcnt == LAST;
                r_oshf  <= r_shf[r_rsel];
                r_obank <= r_rsel;
            end
            if (w_adv) r_ov <= w_rd;
            if (w_xfer) r_sat <= out_last ? 1'b0 : out_sat;
            r_done <= w_rel;
        end
    end
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// tb_fft_reorder_buffer: scoreboard bench for the reorder/widening frame buffer at N=8
module tb_fft_reorder_buffer;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        reorder_en;
    logic [1:0]  shift;
    logic [35:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        out_sat;
    logic        done;

    fft_reorder_buffer #(.N(N), .IN_W(32), .OUT_W(36), .SHIFT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .reorder_en(reorder_en), .shift(shift), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .out_sat(out_sat), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [35:0] d;
        logic        last;
        logic        sat;
    } exp_t;

    typedef struct {
        logic [15:0] re, im;
        logic [1:0]  sh;
        logic [17:0] ere, eim;
        logic        esat;
    } wvec_t;

    exp_t        sb[$];
    exp_t        e_cur;
    int          n_chk = 0, n_pass = 0;
    int          last_in_cyc = 0;
    logic [31:0] fr [N];
    logic        prev_xl = 1'b0, prev_stall = 1'b0, prev_last = 1'b0, prev_sat = 1'b0;
    logic [35:0] prev_d = '0;
    bit          rnd_on = 0, c_done = 0;
    wvec_t       tbl [6];
    int          ord [N];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    function automatic logic [18:0] mwiden(input logic [15:0] x, input int s);
        longint v;
        logic [18:0] r;
        v = longint'($signed(x)) * (longint'(1) << s);
        if (v > 131071) r = {1'b1, 18'h1FFFF};
        else if (v < -131072) r = {1'b1, 18'h20000};
        else r = {1'b0, v[17:0]};
        return r;
    endfunction

    function automatic int brev3(input int p);
        return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
    endfunction

    task automatic push_model(input logic [31:0] s [N], input logic rev, input logic [1:0] sh);
        logic        sat;
        logic [18:0] r, m;
        int          k;
        sat = 1'b0;
        for (int p = 0; p < N; p++) begin
            k = rev ? brev3(p) : p;
            r = mwiden(s[k][31:16], int'(sh));
            m = mwiden(s[k][15:0], int'(sh));
            sat = sat | r[18] | m[18];
            sb.push_back('{{r[17:0], m[17:0]}, p == N - 1, sat});
        end
    endtask

    task automatic send_frame(input logic [31:0] s [N], input int cnt, input logic rev,
                              input logic [1:0] sh, input bit gaps, input bit push);
        logic acc;
        int   t;
        if (push) push_model(s, rev, sh);
        for (int i = 0; i < cnt; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid   = 1'b1;
            in_data    = s[i];
            reorder_en = rev;
            shift      = sh;
            t = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                if (acc && i == N - 1) last_in_cyc = cyc;
                @(posedge clk);
                #1;
                t++;
            end while (!acc && t < 300);
            if (!acc) begin
                chk("in_accept_timeout", 64'(acc), 64'(1));
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clk);
        chk("drain_remaining", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    // output monitor: scoreboard pop, stall stability and done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_xl    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_data", 64'(out_data), 64'(prev_d));
                chk("stall_last", 64'(out_last), 64'(prev_last));
                chk("stall_sat", 64'(out_sat), 64'(prev_sat));
            end
            if (done || prev_xl) chk("done_pulse", 64'(done), 64'(prev_xl));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_output", 64'(1), 64'(0));
                else begin
                    e_cur = sb.pop_front();
                    chk("out_data", 64'(out_data), 64'(e_cur.d));
                    chk("out_last", 64'(out_last), 64'(e_cur.last));
                    if (e_cur.last) chk("out_sat", 64'(out_sat), 64'(e_cur.sat));
                end
            end
            prev_xl    = out_valid && out_ready && out_last;
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_last  = out_last;
            prev_sat   = out_sat;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{16'h7FFF, 16'h8000, 2'd3, 18'h1FFFF, 18'h20000, 1'b1};
        tbl[1] = '{16'h0001, 16'hFFFF, 2'd0, 18'h00001, 18'h3FFFF, 1'b0};
        tbl[2] = '{16'h4000, 16'hC000, 2'd3, 18'h1FFFF, 18'h20000, 1'b1};
        tbl[3] = '{16'h7FFF, 16'h8000, 2'd2, 18'h1FFFC, 18'h20000, 1'b0};
        tbl[4] = '{16'h7FFF, 16'h8000, 2'd0, 18'h07FFF, 18'h38000, 1'b0};
        tbl[5] = '{16'h1234, 16'hFEDC, 2'd1, 18'h02468, 18'h3FDB8, 1'b0};
        ord = '{0, 4, 2, 6, 1, 5, 3, 7};

        in_valid = 1'b0; in_data = '0; reorder_en = 1'b0; shift = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_out_sat", 64'(out_sat), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // bit-reversed frame re=i, im=-i, plus first-output latency
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) fr[i] = {16'(i), 16'(-i)};
        for (int p = 0; p < N; p++) sb.push_back('{{18'(ord[p]), 18'(-ord[p])}, p == N - 1, 1'b0});
        send_frame(fr, N, 1'b1, 2'd0, 0, 0);
        begin
            int t;
            t = 0;
            while (t < 20) begin
                @(negedge clk);
                if (out_valid) break;
                t++;
            end
            chk("first_out_latency", 64'(cyc - last_in_cyc), 64'(2));
        end
        wait_drain();

        // same frame in natural order
        for (int p = 0; p < N; p++) sb.push_back('{{18'(p), 18'(-p)}, p == N - 1, 1'b0});
        send_frame(fr, N, 1'b0, 2'd0, 0, 0);
        wait_drain();

        // widening table, one constant frame per row
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) fr[i] = {tbl[r].re, tbl[r].im};
            for (int p = 0; p < N; p++) sb.push_back('{{tbl[r].ere, tbl[r].eim}, p == N - 1, tbl[r].esat});
            send_frame(fr, N, 1'($urandom_range(0, 1)), tbl[r].sh, 0, 0);
            wait_drain();
        end

        // three frames into a stalled sink
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) fr[i] = {16'(100 + i), 16'(-(100 + i))};
        send_frame(fr, N, 1'b1, 2'd0, 0, 1);
        for (int i = 0; i < N; i++) fr[i] = {16'(200 + i), 16'(300 + i)};
        send_frame(fr, N, 1'b0, 2'd1, 0, 1);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        chk("bp_out_valid_held", 64'(out_valid), 64'(1));
        for (int i = 0; i < N; i++) fr[i] = {16'(16'h7000 + i), 16'(16'h9000 + i)};
        c_done = 0;
        fork
            begin
                send_frame(fr, N, 1'b1, 2'd2, 0, 1);
                c_done = 1;
            end
        join_none
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        begin
            int t;
            t = 0;
            while (t < 40) begin
                @(negedge clk);
                if (out_valid && out_last) break;
                t++;
            end
            chk("bp_in_ready_at_last", 64'(in_ready), 64'(0));
            @(negedge clk);
            chk("bp_in_ready_after_last", 64'(in_ready), 64'(1));
        end
        for (int t = 0; t < 200 && !c_done; t++) @(posedge clk);
        chk("bp_third_frame_sent", 64'(c_done), 64'(1));
        #1;
        wait_drain();

        // random backpressure and input gaps over 50 frames
        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        join_none
        for (int f = 0; f < 50; f++) begin
            for (int i = 0; i < N; i++) fr[i] = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 4095));
            send_frame(fr, N, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1, 1);
        end
        rnd_on = 0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // reset mid-operation, then a clean frame
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) fr[i] = {16'(50 + i), 16'(60 + i)};
        send_frame(fr, N, 1'b0, 2'd0, 0, 1);
        send_frame(fr, 5, 1'b1, 2'd1, 0, 0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        chk("mid_rst_out_last", 64'(out_last), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) fr[i] = {16'(16'h4000 + i), 16'(16'hBFF0 - i)};
        send_frame(fr, N, 1'b1, 2'd1, 0, 1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
